// File: rtl/req_rr_sched_pkg.sv
// Shared types and constants for the req_rr_sched arbiter slice.
package req_rr_sched_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/req_rr_sched_rr_pick.sv
// Combinational requester picker for req_rr_sched.
// Define RR_SCHED_PRIO_EN for fixed priority (highest index wins); default is round-robin from start.
module rr_pick
    import req_rr_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;

    assign cand  = req & mask;
    assign found = |cand;

`ifdef RR_SCHED_PRIO_EN
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) idx = IDX_W'(i);
        end
    end
`else
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 hit;

    // Rotate so that position 0 is the start index, then take the lowest set bit.
    assign dbl = {cand, cand} >> start;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                idx = start + IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/req_rr_sched.sv
// Dwell-based request scheduler: one owner holds the grant for DWELL_CYCLES, then re-arbitrates.
// Picker policy is selected by RR_SCHED_PRIO_EN inside rr_pick.
module req_rr_sched
    import req_rr_sched_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               no_req
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   last_owner, last_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt;
    logic [NUM_REQ-1:0] onehot_nxt;
    logic               no_req_nxt;

    logic               release_own;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    // Release takes precedence over expiry: the departing owner is masked out.
    assign release_own = (state == OWN) && !req[grant_idx];
    assign pick_mask   = release_own ? ~(NUM_REQ'(1) << grant_idx) : '1;
    assign pick_start  = last_owner + IDX_W'(1);

    rr_pick u_pick (
        .req   (req),
        .mask  (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_owner   <= '1;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            no_req       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            last_owner   <= last_nxt;
            grant_idx    <= idx_nxt;
            grant_valid  <= valid_nxt;
            grant_onehot <= onehot_nxt;
            no_req       <= no_req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last_owner;
        idx_nxt   = grant_idx;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state_nxt = OWN;
                        cnt_nxt   = RELOAD;
                        last_nxt  = pick_idx;
                        idx_nxt   = pick_idx;
                    end
                end
                OWN: begin
                    if (release_own || cnt == '0) begin
                        if (pick_found) begin
                            cnt_nxt  = RELOAD;
                            last_nxt = pick_idx;
                            idx_nxt  = pick_idx;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_nxt  = (state_nxt == OWN);
        onehot_nxt = valid_nxt ? (NUM_REQ'(1) << idx_nxt) : '0;
        no_req_nxt = enable & ~|req;
    end

endmodule

// File: doc/req_rr_sched.md
REQ_RR_SCHED -- requirements
Module: req_rr_sched

Interface
REQ-001 Parameter: DWELL_CYCLES, default 16, meaning the number of cycles one owner holds the grant before re-arbitration; legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, meaning the dwell counter width; the block SHALL assume DWELL_CYCLES <= 2^CNT_W - 1.
REQ-003 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: req, input, 8, one request line per switch requester; index 7 is the highest.
REQ-006 Port: enable, input, 1, scheduler enable; low forces the idle condition.
REQ-007 Port: grant_valid, output, 1, high while an owner holds the grant.
REQ-008 Port: grant_idx, output, 3, binary index of the current owner, for the 7-segment and LED path.
REQ-009 Port: grant_onehot, output, 8, one-hot form of grant_idx; all zero when grant_valid is low.
REQ-010 Port: no_req, output, 1, high when enable is high and req is all zero.

Function
REQ-011 All outputs SHALL be registered; req and enable sampled at edge N SHALL affect the outputs at edge N only.
REQ-012 FSM states: IDLE (no owner) and OWN (owner latched, dwell counter running).
REQ-013 IDLE->OWN: when enable is 1 and req is nonzero, the picked requester is latched, grant_valid rises and the counter loads DWELL_CYCLES-1.
REQ-014 OWN: the counter decrements by one per cycle while the owner's req bit stays high and enable stays high.
REQ-015 Dwell expiry (counter 0 in OWN): re-arbitrate in the same edge; if any req is high, the new owner is picked and the counter reloads; if none is high, go to IDLE.
REQ-016 Owner release: if the owner's req bit is low in OWN, re-arbitrate at that edge, excluding the departing owner; go to IDLE if no other request exists.
REQ-017 Round-robin pick: search starts at (last_owner+1) mod 8 and moves upward with wrap; after reset, last_owner is 7, so index 0 is searched first.
REQ-018 A sole requester whose dwell expires SHALL be re-granted immediately, with no idle cycle between grants.
REQ-019 enable low in any state: next edge goes to IDLE, grant_valid is 0, grant_onehot is 0, and last_owner is kept.
REQ-020 While grant_valid is 0, grant_idx SHALL hold its last value; grant_idx is 0 after reset.
REQ-021 no_req is registered as enable & ~|req, independent of the FSM state.
REQ-022 Simultaneous release and expiry SHALL be treated as a release (REQ-016).

Reset
REQ-023 On rst high, asynchronously: state IDLE, grant_valid 0, grant_idx 0, grant_onehot 0, no_req 0, counter 0, last_owner 7.
REQ-024 Reset asserted mid-OWN SHALL abort the grant with no partial dwell retained; arbitration after release starts from index 0.

Configuration
REQ-025 Macro RR_SCHED_PRIO_EN defined: the picker SHALL be fixed priority, highest set index wins, and last_owner is ignored; dwell and release rules are unchanged.
REQ-026 Macro RR_SCHED_PRIO_EN undefined: round-robin per REQ-017.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding (IDLE, OWN), the requester count constant of 8, and the index width constant of 3.
REQ-028 One combinational sub-module, rr_pick, SHALL take req, a mask and a start pointer, and return found and idx; the macro selection lives only inside it.
REQ-029 The top SHALL contain the FSM, the counter, last_owner and the output registers; expected size is 120-400 lines of RTL.

Verification
REQ-030 Reset, then req=8'h00, enable=1 -> grant_valid=0, no_req=1 after one edge, grant_idx=0.
REQ-031 DWELL_CYCLES=4, req=8'h81 held -> owner 0 for 4 cycles, then 7 for 4 cycles, then 0 again, with no gap cycles.
REQ-032 Owner 3 granted with req=8'h28, drop req[3] at cycle 2 -> next edge owner 5, counter reloaded.
REQ-033 enable pulsed low for one cycle during OWN with req=8'h04 -> grant_valid=0 for one cycle, then owner 2 regranted.
REQ-034 rst asserted asynchronously mid-dwell -> all outputs zero immediately, without waiting for a clock edge; after release with req=8'hFF -> owner 0.
REQ-035 With RR_SCHED_PRIO_EN defined, req=8'h13, DWELL_CYCLES=2 -> owner 4 continuously, and 0 and 1 are never granted.
